// File: rtl/axi4lite_sram_slave.sv
// Single-port SRAM behind an AXI4-Lite slave; one outstanding transaction,
// writes take priority over reads, and there are no response codes.
module axi4lite_sram_slave #(
  parameter int unsigned MEM_WORDS    = 1024,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        AWvalid,
  input  logic [31:0] AWdata,
  input  logic [2:0]  AWprot,
  output logic        AWready,
  input  logic        Wvalid,
  input  logic [31:0] Wdata,
  input  logic [3:0]  Wstrb,
  output logic        Wready,
  output logic        Bvalid,
  input  logic        Bready,
  input  logic        ARvalid,
  input  logic [31:0] ARdata,
  input  logic [2:0]  ARprot,
  output logic        ARready,
  output logic        Rvalid,
  output logic [31:0] Rdata,
  input  logic        RReady
);

  localparam int unsigned AW   = $clog2(MEM_WORDS);
  localparam logic [32:0] SPAN = 33'(MEM_WORDS) * 33'd4;

  typedef enum logic [2:0] {IDLE, WRITE, WRESP, READ, RRESP} state_t;

  state_t      state;
  logic        aw_cap, w_cap;
  logic [31:0] aw_addr, ar_addr, w_data;
  logic [3:0]  w_strb;
  logic [2:0]  lat_cnt;
  logic [31:0] mem [MEM_WORDS];

  logic aw_hs, w_hs, ar_hs;
  logic unused_prot;

  assign unused_prot = ^{AWprot, ARprot};

  // Offset is formed in 33 bits so addresses below the base wrap to a huge
  // value and fail the single range comparison.
  function automatic logic addr_hit(input logic [31:0] a);
    logic [32:0] off;
    off = {1'b0, a} - {1'b0, BASE_ADDR};
    return off < SPAN;
  endfunction

  function automatic logic [AW-1:0] word_idx(input logic [31:0] a);
    return AW'((a - BASE_ADDR) >> 2);
  endfunction

  assign AWready = !rst && (state == IDLE) && !aw_cap;
  assign Wready  = !rst && (state == IDLE) && !w_cap;
  assign ARready = !rst && (state == IDLE) && !aw_cap && !w_cap && !AWvalid && !Wvalid;

  assign aw_hs = AWvalid && AWready;
  assign w_hs  = Wvalid && Wready;
  assign ar_hs = ARvalid && ARready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      aw_cap  <= 1'b0;
      w_cap   <= 1'b0;
      lat_cnt <= '0;
      Bvalid  <= 1'b0;
      Rvalid  <= 1'b0;
      Rdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (aw_hs) aw_cap <= 1'b1;
          if (w_hs)  w_cap  <= 1'b1;
          if ((aw_cap || aw_hs) && (w_cap || w_hs)) begin
            state <= WRITE;
          end else if (ar_hs) begin
            lat_cnt <= 3'(READ_LATENCY - 1);
            state   <= READ;
          end
        end
        WRITE: begin
          aw_cap <= 1'b0;
          w_cap  <= 1'b0;
          Bvalid <= 1'b1;
          state  <= WRESP;
        end
        WRESP: begin
          if (Bready) begin
            Bvalid <= 1'b0;
            state  <= IDLE;
          end
        end
        READ: begin
          if (lat_cnt == '0) begin
            Rdata  <= addr_hit(ar_addr) ? mem[word_idx(ar_addr)] : '0;
            Rvalid <= 1'b1;
            state  <= RRESP;
          end else begin
            lat_cnt <= lat_cnt - 3'd1;
          end
        end
        RRESP: begin
          if (RReady) begin
            Rvalid <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Captured request fields and the array itself carry no reset.
  always_ff @(posedge clk) begin
    if (aw_hs) aw_addr <= AWdata;
    if (w_hs) begin
      w_data <= Wdata;
      w_strb <= Wstrb;
    end
    if (ar_hs) ar_addr <= ARdata;
    if (state == WRITE && !rst && addr_hit(aw_addr)) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (w_strb[i]) mem[word_idx(aw_addr)][8*i +: 8] <= w_data[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axi4lite_sram_slave.sv
// Randomized scoreboard bench for axi4lite_sram_slave against a word-array
// reference model; a negedge monitor checks every B/R handshake.
module tb_axi4lite_sram_slave;

  localparam int unsigned MW   = 64;
  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int unsigned RL   = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        AWvalid = 1'b0, Wvalid = 1'b0, ARvalid = 1'b0;
  logic        Bready = 1'b0, RReady = 1'b0;
  logic [31:0] AWdata = '0, Wdata = '0, ARdata = '0;
  logic [3:0]  Wstrb = '0;
  logic [2:0]  AWprot = '0, ARprot = '0;
  logic        AWready, Wready, Bvalid, ARready, Rvalid;
  logic [31:0] Rdata;

  axi4lite_sram_slave #(
    .MEM_WORDS(MW), .BASE_ADDR(BASE), .READ_LATENCY(RL)
  ) dut (
    .clk(clk), .rst(rst),
    .AWvalid(AWvalid), .AWdata(AWdata), .AWprot(AWprot), .AWready(AWready),
    .Wvalid(Wvalid), .Wdata(Wdata), .Wstrb(Wstrb), .Wready(Wready),
    .Bvalid(Bvalid), .Bready(Bready),
    .ARvalid(ARvalid), .ARdata(ARdata), .ARprot(ARprot), .ARready(ARready),
    .Rvalid(Rvalid), .Rdata(Rdata), .RReady(RReady)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] ref_mem [MW];
  logic [31:0] exp_r [$];
  int          b_pending = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic void note_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s: bound expired", name);
  endfunction

  // Reference model: byte address -> word array, misses read as zero.
  function automatic bit model_hit(input logic [31:0] a);
    longint unsigned la = a;
    return la >= longint'(BASE) && la < longint'(BASE) + 4 * longint'(MW);
  endfunction

  function automatic void model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    if (model_hit(a)) begin
      int unsigned idx = (a - BASE) / 4;
      for (int b = 0; b < 4; b++)
        if (s[b]) ref_mem[idx][8*b +: 8] = d[8*b +: 8];
    end
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (!model_hit(a)) return 32'h0;
    return ref_mem[(a - BASE) / 4];
  endfunction

  // Monitor: pops the scoreboard on each handshake and checks read latency.
  int   ar_cyc = 0;
  logic r_prev = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      if (ARvalid && ARready) ar_cyc = cyc;
      if (Rvalid && !r_prev) chk("r_latency", 32'(cyc - ar_cyc), 32'(RL + 1));
      if (Bvalid && Bready) begin
        chk("b_expected", 32'(b_pending > 0), 32'd1);
        if (b_pending > 0) b_pending--;
      end
      if (Rvalid && RReady) begin
        if (exp_r.size() == 0) note_fail("r_unexpected");
        else chk("rdata", Rdata, exp_r.pop_front());
      end
    end
    r_prev = Rvalid;
  end

  task automatic send_aw(input logic [31:0] a, input int dly);
    repeat (dly) begin @(posedge clk); #1; end
    AWvalid = 1'b1; AWdata = a;
    for (int t = 0; ; t++) begin
      @(negedge clk);
      if (AWready) break;
      if (t > 300) begin note_fail("aw_timeout"); break; end
    end
    @(posedge clk); #1;
    AWvalid = 1'b0;
    chk("awready_drop", 32'(AWready), 32'd0);
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s, input int dly);
    repeat (dly) begin @(posedge clk); #1; end
    Wvalid = 1'b1; Wdata = d; Wstrb = s;
    for (int t = 0; ; t++) begin
      @(negedge clk);
      if (Wready) break;
      if (t > 300) begin note_fail("w_timeout"); break; end
    end
    @(posedge clk); #1;
    Wvalid = 1'b0;
    chk("wready_drop", 32'(Wready), 32'd0);
  endtask

  task automatic send_ar(input logic [31:0] a);
    ARvalid = 1'b1; ARdata = a;
    for (int t = 0; ; t++) begin
      @(negedge clk);
      if (ARready) break;
      if (t > 300) begin note_fail("ar_timeout"); break; end
    end
    @(posedge clk); #1;
    ARvalid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int t = 0; ; t++) begin
      @(negedge clk);
      if (exp_r.size() == 0 && b_pending == 0) break;
      if (t > 300) begin note_fail("drain_timeout"); break; end
    end
    @(posedge clk); #1;
  endtask

  // Holds Bready low while Bvalid is seen for bdly cycles, then accepts.
  task automatic finish_b(input int bdly);
    int t = 0, hi;
    do begin @(negedge clk); t++; end while (!Bvalid && t < 300);
    if (!Bvalid) begin note_fail("b_timeout"); return; end
    hi = 1;
    while (hi < bdly) begin
      @(negedge clk);
      if (Bvalid) hi++; else break;
    end
    chk("b_hold", 32'(hi), 32'(bdly));
    @(posedge clk); #1;
    Bready = 1'b1;
    wait_drain();
    Bready = 1'b0;
  endtask

  task automatic finish_r(input int rdly);
    int t = 0;
    logic [31:0] first;
    do begin @(negedge clk); t++; end while (!Rvalid && t < 300);
    if (!Rvalid) begin note_fail("r_timeout"); return; end
    first = Rdata;
    for (int i = 1; i < rdly; i++) begin
      @(negedge clk);
      chk("r_hold_valid", 32'(Rvalid), 32'd1);
      chk("r_hold_data", Rdata, first);
    end
    @(posedge clk); #1;
    RReady = 1'b1;
    wait_drain();
    RReady = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int da, input int dw, input int bdly);
    model_write(a, d, s);
    b_pending++;
    Bready = (bdly == 0);
    fork
      send_aw(a, da);
      send_w(d, s, dw);
    join
    if (bdly != 0) finish_b(bdly);
    else wait_drain();
    Bready = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a, input int rdly);
    exp_r.push_back(model_read(a));
    RReady = (rdly == 0);
    send_ar(a);
    if (rdly != 0) finish_r(rdly);
    else wait_drain();
    RReady = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ar_hi;
    logic [31:0] a;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_awready", 32'(AWready), 32'd0);
    chk("rst_wready", 32'(Wready), 32'd0);
    chk("rst_arready", 32'(ARready), 32'd0);
    chk("rst_bvalid", 32'(Bvalid), 32'd0);
    chk("rst_rvalid", 32'(Rvalid), 32'd0);
    chk("rst_rdata", Rdata, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < int'(MW); i++) do_write(BASE + 32'(4 * i), $urandom, 4'hF, 0, 0, 0);

    do_write(32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 1);
    do_read(32'h10, 0);
    do_write(32'h10, 32'h0000_5500, 4'b0010, 0, 0, 0);
    do_read(32'h10, 0);

    // W three cycles ahead of AW, Bready held off; ARready must stay low.
    model_write(32'h14, 32'hA5A5_0F0F, 4'hF);
    b_pending++;
    Bready = 1'b0;
    send_w(32'hA5A5_0F0F, 4'hF, 0);
    ar_hi = 0;
    fork
      send_aw(32'h14, 2);
      for (int i = 0; i < 12; i++) begin @(negedge clk); if (ARready) ar_hi++; end
    join
    chk("arready_blocked", 32'(ar_hi), 32'd0);
    finish_b(4);
    do_read(32'h14, 2);

    // Simultaneous AW, W and AR: the write must land before the read.
    model_write(32'h20, 32'h1234_5678, 4'hF);
    b_pending++;
    exp_r.push_back(model_read(32'h20));
    Bready = 1'b1; RReady = 1'b1;
    fork
      send_aw(32'h20, 0);
      send_w(32'h1234_5678, 4'hF, 0);
      send_ar(32'h20);
    join
    wait_drain();
    Bready = 1'b0; RReady = 1'b0;

    do_read(BASE + 32'(4 * MW), 1);
    do_write(BASE + 32'(4 * MW), 32'hFFFF_FFFF, 4'hF, 1, 0, 2);
    do_read(BASE, 0);

    // Reset while a read response is held.
    exp_r.push_back(model_read(32'h10));
    RReady = 1'b0;
    send_ar(32'h10);
    for (int t = 0; t < 300 && !Rvalid; t++) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_rvalid", 32'(Rvalid), 32'd0);
    chk("async_rst_rdata", Rdata, 32'h0);
    exp_r.delete();
    #4 rst = 1'b0;
    @(posedge clk); #1;
    do_read(32'h10, 1);

    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 9) == 0) a = $urandom;
      else a = BASE + 32'(4 * $urandom_range(0, MW - 1)) + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1)
        do_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                 $urandom_range(0, 3), $urandom_range(0, 3));
      else
        do_read(a, $urandom_range(0, 3));
    end

    wait_drain();
    chk("final_r_queue", 32'(exp_r.size()), 32'd0);
    chk("final_b_pending", 32'(b_pending), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
